complex_accumulator_mc: RTL and testbench
=========================================

# complex_accumulator_mc

Multi-channel, parametrised successor to the single-channel complex accumulator in the FFT convolution datapath. It sums framed streams of complex fixed-point samples, one running sum per channel, with channels freely interleaved beat by beat. Each sum has guard bits, and overflow is handled in either wrap or saturate mode. A frame's result is presented through a valid/ready output register. The block sits between the frequency-domain multiplier array and the inverse-FFT input buffer.

## Interface
- `DATA_WIDTH`, 16: width of each real and imaginary input component (signed).
- `GUARD_BITS`, 4: extra accumulator bits; `ACC_WIDTH = DATA_WIDTH + GUARD_BITS`.
- `NUM_CH`, 4: number of independent accumulation channels (≥1); `CH_W = max(1, $clog2(NUM_CH))`.
- `MODE`, `ACC_WRAP`: overflow policy, either `ACC_WRAP` or `ACC_SAT`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `in_r`, `in_i` in `DATA_WIDTH` each: input sample, signed.
- `in_ch` in `CH_W`: channel of the current beat.
- `in_first` in 1: beat starts a frame.
- `in_last` in 1: beat ends a frame.
- `in_valid` in 1: beat present.
- `in_ready` out 1: beat accepted when `in_valid & in_ready`.
- `out_r`, `out_i` out `ACC_WIDTH` each: frame sum, signed.
- `out_ch` out `CH_W`: channel of the result.
- `out_overflow` out 1: set if any add in the frame overflowed (saturated in `ACC_SAT`, wrapped in `ACC_WRAP`).
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer takes the result when `out_valid & out_ready`.
- `protocol_err` out 1: one-cycle pulse on a framing violation.

## Operation
- Per channel state: `active` bit (IDLE/RUN), `acc_r`, `acc_i` (`ACC_WIDTH` each), sticky `ovf`.
- Input is sign-extended to `ACC_WIDTH` before any add.
- Accept with `in_first=1`:
  - `acc <= ext(in)`, `ovf <= 0`, `active <= 1`.
  - If the channel was already active, the old partial sum is discarded and `protocol_err` pulses.
- Accept with `in_first=0` on an active channel: `acc <= acc + ext(in)` per component.
- Accept with `in_first=0` on an idle channel: the beat is treated as `in_first=1` and `protocol_err` pulses.
- Overflow rules:
  - `ACC_WRAP`: the sum is two's-complement modulo 2^ACC_WIDTH, and `ovf` is set on signed overflow.
  - `ACC_SAT`: each component clamps to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1] independently, and `ovf` is set.
- Accept with `in_last=1`:
  - The updated sum, including this beat, loads the output register with `out_ch` and `out_overflow`, and `out_valid <= 1`.
  - The channel returns to IDLE.
- `in_first=1` with `in_last=1` is a single-beat frame: output = `ext(in)`, overflow 0.
- `in_ready = !out_valid | out_ready`. All input, not only last beats, stalls while the output is held.
- Simultaneous events:
  - When the output drains and a last beat is accepted in the same cycle, the output reloads and `out_valid` stays 1.
  - When the output drains with no new last beat, `out_valid <= 0`.
- `out_*` data is stable while `out_valid & !out_ready`.
- Accumulation state is registered only. There is no combinational path from `in_*` to `out_*`.

## Timing
- Accumulation update: 1 cycle. A beat accepted at edge k is visible in `acc` after edge k.
- Result latency: a last beat accepted at edge k gives `out_valid` high from edge k, i.e. visible in cycle k+1.
- Throughput: 1 beat per cycle per block, any channel order, when `out_ready` is held high.
- `in_ready` is combinational from `out_valid`/`out_ready` only, never from `in_valid`.
- `protocol_err` is registered: it is high for the cycle after the offending accept.
- Reset values:
  - `out_valid`, `out_r`, `out_i`, `out_ch`, `out_overflow`, `protocol_err`: 0.
  - All `active`, `acc` and `ovf`: 0.
  - `in_ready` is 1 after reset.
- Reset mid-frame discards all partial sums and any undelivered output. Beats presented during reset are dropped.

## Structure
- The shared package (alongside `complex_fxp_t`) holds:
  - enum `acc_mode_e {ACC_WRAP, ACC_SAT}`;
  - function `sat_add(a, b, width)` returning the sum and an overflow flag.
- One sub-module: `complex_sat_add`. It is combinational: two components, parametrised `ACC_WIDTH` and `MODE`, outputs sum and overflow. The top instantiates it once and muxes channel state by `in_ch`.
- Channel state is held in register arrays indexed by `in_ch`. No RAM inference is intended for `NUM_CH` ≤ 16.

## Test plan
- Single-channel sum, `ch0`, `out_ready=1`: beats (1,−1), (2,−2), (3,−3) with first/last on beats 1 and 3 → one result (6,−6), `out_ch=0`, `out_overflow=0`, in cycle after the last accept.
- Interleaved frames, `NUM_CH=4`: beats ch0 +10, ch1 +100, ch0 +20 (last), ch1 +200 (last) → results ch0 30, then ch1 300, on consecutive cycles.
- Saturation, `DATA_WIDTH=16`, `GUARD_BITS=0`:
  - `ACC_SAT`: 32767 + 1 → `out_r=32767`, `out_overflow=1`.
  - `ACC_WRAP`: 32767 + 1 → `out_r=−32768`, `out_overflow=1`.
- Backpressure, `out_ready=0` for 5 cycles after a result: `in_ready=0`, output stable, no beat lost. Raising `out_ready` with a pending last beat → drain and reload in the same cycle, with `out_valid` continuously 1.
- Framing errors:
  - Non-first beat to an idle channel → `protocol_err` pulse, and the frame starts from that beat.
  - `in_first` on an active channel → pulse, and the old sum is discarded.
  - Single-beat frame (first and last) of (−5,7) → output (−5,7).
- Reset mid-frame: 2 beats into ch2, assert `reset` 1 cycle, then a fresh first..last frame of 4 → result 4, all outputs 0 during and after reset, `in_ready=1`.

Source files
------------

// File: rtl/complex_accumulator_mc_pkg.sv
// rtl/complex_accumulator_mc_pkg.sv - shared types and overflow-aware adder for the complex accumulator
package complex_accumulator_mc_pkg;

    typedef enum logic {
        ACC_WRAP,
        ACC_SAT
    } acc_mode_e;

    localparam int FXP_W     = 16;
    localparam int SAT_MAX_W = 64;

    typedef struct packed {
        logic signed [FXP_W-1:0] r;
        logic signed [FXP_W-1:0] i;
    } complex_fxp_t;

    typedef struct packed {
        logic [SAT_MAX_W-1:0] sum;
        logic                 ovf;
    } sat_res_t;

    // Operands arrive sign-extended to SAT_MAX_W; width (< SAT_MAX_W) is the modelled accumulator width.
    // The returned sum is sign-extended from bit width-1 in both wrap and saturate cases.
    function automatic sat_res_t sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input int                   width,
        input logic                 sat
    );
        sat_res_t             res;
        logic [SAT_MAX_W-1:0] raw;
        logic [SAT_MAX_W-1:0] low_mask;
        logic [SAT_MAX_W-1:0] sign_mask;
        logic [SAT_MAX_W-1:0] max_val;
        logic                 sa;
        logic                 sb;
        logic                 sr;
        raw       = a + b;
        low_mask  = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
        sign_mask = SAT_MAX_W'(1) << (width - 1);
        max_val   = low_mask >> 1;
        sa        = (a & sign_mask) != '0;
        sb        = (b & sign_mask) != '0;
        sr        = (raw & sign_mask) != '0;
        res.ovf   = (sa == sb) && (sr != sa);
        if (res.ovf && sat) begin
            res.sum = sa ? ~max_val : max_val;
        end else begin
            res.sum = sr ? (raw | ~low_mask) : (raw & low_mask);
        end
        return res;
    endfunction

endpackage

// File: rtl/complex_accumulator_mc_sat_add.sv
// rtl/complex_accumulator_mc_sat_add.sv - combinational complex adder with wrap or saturate overflow policy
module complex_sat_add
    import complex_accumulator_mc_pkg::*;
#(
    parameter int        ACC_WIDTH = 20,
    parameter acc_mode_e MODE      = ACC_WRAP
) (
    input  logic signed [ACC_WIDTH-1:0] a_r,
    input  logic signed [ACC_WIDTH-1:0] a_i,
    input  logic signed [ACC_WIDTH-1:0] b_r,
    input  logic signed [ACC_WIDTH-1:0] b_i,
    output logic signed [ACC_WIDTH-1:0] sum_r,
    output logic signed [ACC_WIDTH-1:0] sum_i,
    output logic                        ovf
);

    sat_res_t res_r;
    sat_res_t res_i;
    logic     unused_hi;

    always_comb begin
        res_r = sat_add(SAT_MAX_W'(a_r), SAT_MAX_W'(b_r), ACC_WIDTH, MODE == ACC_SAT);
        res_i = sat_add(SAT_MAX_W'(a_i), SAT_MAX_W'(b_i), ACC_WIDTH, MODE == ACC_SAT);
    end

    assign sum_r = res_r.sum[ACC_WIDTH-1:0];
    assign sum_i = res_i.sum[ACC_WIDTH-1:0];
    assign ovf   = res_r.ovf || res_i.ovf;

    // Upper bits are only sign extension of the in-range result.
    assign unused_hi = ^{res_r.sum[SAT_MAX_W-1:ACC_WIDTH], res_i.sum[SAT_MAX_W-1:ACC_WIDTH]};

endmodule

// File: rtl/complex_accumulator_mc.sv
// rtl/complex_accumulator_mc.sv - multi-channel framed complex accumulator with registered valid/ready result
module complex_accumulator_mc
    import complex_accumulator_mc_pkg::*;
#(
    parameter int        DATA_WIDTH = 16,
    parameter int        GUARD_BITS = 4,
    parameter int        NUM_CH     = 4,
    parameter acc_mode_e MODE       = ACC_WRAP,
    localparam int       ACC_WIDTH  = DATA_WIDTH + GUARD_BITS,
    localparam int       CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] in_r,
    input  logic signed [DATA_WIDTH-1:0] in_i,
    input  logic        [CH_W-1:0]       in_ch,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [ACC_WIDTH-1:0]  out_r,
    output logic signed [ACC_WIDTH-1:0]  out_i,
    output logic        [CH_W-1:0]       out_ch,
    output logic                         out_overflow,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         protocol_err
);

    logic        [NUM_CH-1:0]    active;
    logic        [NUM_CH-1:0]    ovf;
    logic signed [ACC_WIDTH-1:0] acc_r [NUM_CH];
    logic signed [ACC_WIDTH-1:0] acc_i [NUM_CH];

    logic                        fire;
    logic                        cur_active;
    logic                        start;
    logic                        frame_err;
    logic signed [ACC_WIDTH-1:0] ext_r;
    logic signed [ACC_WIDTH-1:0] ext_i;
    logic signed [ACC_WIDTH-1:0] base_r;
    logic signed [ACC_WIDTH-1:0] base_i;
    logic signed [ACC_WIDTH-1:0] sum_r;
    logic signed [ACC_WIDTH-1:0] sum_i;
    logic                        add_ovf;
    logic                        next_ovf;

    // Any held result stalls every channel, so no beat is accepted that could need the output.
    assign in_ready   = !out_valid || out_ready;
    assign fire       = in_valid && in_ready;
    assign cur_active = active[in_ch];

    // A non-first beat on an idle channel restarts the frame exactly like a first beat.
    assign start      = in_first || !cur_active;
    assign frame_err  = fire && (in_first == cur_active);

    assign ext_r  = ACC_WIDTH'(in_r);
    assign ext_i  = ACC_WIDTH'(in_i);
    assign base_r = start ? '0 : acc_r[in_ch];
    assign base_i = start ? '0 : acc_i[in_ch];

    complex_sat_add #(
        .ACC_WIDTH (ACC_WIDTH),
        .MODE      (MODE)
    ) u_add (
        .a_r   (base_r),
        .a_i   (base_i),
        .b_r   (ext_r),
        .b_i   (ext_i),
        .sum_r (sum_r),
        .sum_i (sum_i),
        .ovf   (add_ovf)
    );

    assign next_ovf = !start && (ovf[in_ch] || add_ovf);

    always_ff @(posedge clk) begin
        if (reset) begin
            active       <= '0;
            ovf          <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_r[c] <= '0;
                acc_i[c] <= '0;
            end
            out_r        <= '0;
            out_i        <= '0;
            out_ch       <= '0;
            out_overflow <= 1'b0;
            out_valid    <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            protocol_err <= frame_err;
            if (fire) begin
                acc_r[in_ch]  <= sum_r;
                acc_i[in_ch]  <= sum_i;
                ovf[in_ch]    <= next_ovf;
                active[in_ch] <= !in_last;
            end
            // Reload in the drain cycle keeps out_valid high with no bubble.
            if (fire && in_last) begin
                out_r        <= sum_r;
                out_i        <= sum_i;
                out_ch       <= in_ch;
                out_overflow <= next_ovf;
                out_valid    <= 1'b1;
            end else if (out_ready) begin
                out_valid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_complex_accumulator_mc.sv
// tb/tb_complex_accumulator_mc.sv - directed scoreboard bench for complex_accumulator_mc
module tb_complex_accumulator_mc;
    import complex_accumulator_mc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic signed [15:0] in_r;
    logic signed [15:0] in_i;
    logic [1:0]         in_ch;
    logic               in_first;
    logic               in_last;
    logic               in_valid;
    logic               aux_valid;
    logic               out_ready;

    logic               in_ready;
    logic signed [19:0] out_r;
    logic signed [19:0] out_i;
    logic [1:0]         out_ch;
    logic               out_overflow;
    logic               out_valid;
    logic               protocol_err;

    logic               s_in_ready, w_in_ready;
    logic signed [15:0] s_out_r, s_out_i, w_out_r, w_out_i;
    logic [1:0]         s_out_ch, w_out_ch;
    logic               s_out_overflow, w_out_overflow;
    logic               s_out_valid, w_out_valid;
    logic               s_protocol_err, w_protocol_err;

    complex_accumulator_mc #(.DATA_WIDTH(16), .GUARD_BITS(4), .NUM_CH(4), .MODE(ACC_WRAP)) dut (
        .clk(clk), .reset(reset), .in_r(in_r), .in_i(in_i), .in_ch(in_ch),
        .in_first(in_first), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_r(out_r), .out_i(out_i), .out_ch(out_ch), .out_overflow(out_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .protocol_err(protocol_err)
    );

    complex_accumulator_mc #(.DATA_WIDTH(16), .GUARD_BITS(0), .NUM_CH(4), .MODE(ACC_SAT)) dut_sat (
        .clk(clk), .reset(reset), .in_r(in_r), .in_i(in_i), .in_ch(in_ch),
        .in_first(in_first), .in_last(in_last), .in_valid(aux_valid), .in_ready(s_in_ready),
        .out_r(s_out_r), .out_i(s_out_i), .out_ch(s_out_ch), .out_overflow(s_out_overflow),
        .out_valid(s_out_valid), .out_ready(1'b1), .protocol_err(s_protocol_err)
    );

    complex_accumulator_mc #(.DATA_WIDTH(16), .GUARD_BITS(0), .NUM_CH(4), .MODE(ACC_WRAP)) dut_wrap (
        .clk(clk), .reset(reset), .in_r(in_r), .in_i(in_i), .in_ch(in_ch),
        .in_first(in_first), .in_last(in_last), .in_valid(aux_valid), .in_ready(w_in_ready),
        .out_r(w_out_r), .out_i(w_out_i), .out_ch(w_out_ch), .out_overflow(w_out_overflow),
        .out_valid(w_out_valid), .out_ready(1'b1), .protocol_err(w_protocol_err)
    );

    typedef struct {
        logic signed [19:0] r;
        logic signed [19:0] i;
        logic [1:0]         ch;
        logic               ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] ch, input int r, input int i, input logic o);
        exp_t e;
        e.r   = 20'(r);
        e.i   = 20'(i);
        e.ch  = ch;
        e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic beat(input logic [1:0] ch, input int r, input int i,
                        input logic f, input logic l, input logic aux = 1'b0);
        int n;
        in_ch     = ch;
        in_r      = 16'(r);
        in_i      = 16'(i);
        in_first  = f;
        in_last   = l;
        in_valid  = !aux;
        aux_valid = aux;
        n = 0;
        @(negedge clk);
        while (!aux && !in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("beat_accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        aux_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            exp_t e;
            n_cmp++;
            assert (sb.size() > 0)
            else begin
                n_err++;
                $error("FAIL sb_unexpected: observed result ch %0d r %0d, expected none", out_ch, out_r);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_r", out_r, e.r);
                chk("sb_i", out_i, e.i);
                chk("sb_ch", out_ch, e.ch);
                chk("sb_ovf", out_overflow, e.ovf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; aux_valid = 1'b0; out_ready = 1'b1;
        in_first = 1'b0; in_last = 1'b0; in_r = '0; in_i = '0; in_ch = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_i", out_i, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_ovf", out_overflow, 0);
        chk("rst_perr", protocol_err, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        // single-channel three-beat frame
        push(0, 6, -6, 0);
        beat(0, 1, -1, 1, 0);
        beat(0, 2, -2, 0, 0);
        beat(0, 3, -3, 0, 1);
        chk("t1_valid", out_valid, 1);
        chk("t1_r", out_r, 6);
        chk("t1_perr", protocol_err, 0);

        // interleaved channels, results on consecutive cycles
        push(0, 30, -30, 0);
        push(1, 300, -300, 0);
        beat(0, 10, -10, 1, 0);
        beat(1, 100, -100, 1, 0);
        beat(0, 20, -20, 0, 1);
        chk("t2_ch0_ch", out_ch, 0);
        chk("t2_ch0_r", out_r, 30);
        beat(1, 200, -200, 0, 1);
        chk("t2_ch1_valid", out_valid, 1);
        chk("t2_ch1_ch", out_ch, 1);
        chk("t2_ch1_r", out_r, 300);

        // overflow with zero guard bits
        beat(0, 32767, 0, 1, 0, 1'b1);
        beat(0, 1, 0, 0, 1, 1'b1);
        chk("sat_pos_valid", s_out_valid, 1);
        chk("sat_pos_r", s_out_r, 32767);
        chk("sat_pos_ovf", s_out_overflow, 1);
        chk("wrap_pos_r", w_out_r, -32768);
        chk("wrap_pos_ovf", w_out_overflow, 1);
        beat(1, -32768, 0, 1, 0, 1'b1);
        beat(1, -1, 5, 0, 1, 1'b1);
        chk("sat_neg_r", s_out_r, -32768);
        chk("sat_neg_i", s_out_i, 5);
        chk("sat_neg_ovf", s_out_overflow, 1);
        chk("wrap_neg_r", w_out_r, 32767);
        chk("wrap_neg_ovf", w_out_overflow, 1);

        // backpressure with a pending last beat, then drain and reload together
        push(3, 7, 8, 0);
        push(2, 11, 11, 0);
        beat(2, 5, 5, 1, 0);
        beat(3, 7, 8, 1, 1);
        out_ready = 1'b0;
        in_ch = 2; in_r = 6; in_i = 6; in_first = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_r", out_r, 7);
            chk("bp_ch", out_ch, 3);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("reload_valid", out_valid, 1);
        chk("reload_r", out_r, 11);
        chk("reload_i", out_i, 11);
        chk("reload_ch", out_ch, 2);
        chk("reload_perr", protocol_err, 0);

        // framing errors
        beat(1, 4, 4, 0, 0);
        chk("perr_idle_nonfirst", protocol_err, 1);
        push(1, 5, 5, 0);
        beat(1, 1, 1, 0, 1);
        chk("perr_idle_clear", protocol_err, 0);
        chk("idle_frame_r", out_r, 5);
        beat(0, 100, 0, 1, 0);
        chk("perr_first_ok", protocol_err, 0);
        beat(0, 3, 3, 1, 0);
        chk("perr_restart", protocol_err, 1);
        push(0, 5, 5, 0);
        beat(0, 2, 2, 0, 1);
        chk("restart_r", out_r, 5);
        push(0, -5, 7, 0);
        beat(0, -5, 7, 1, 1);
        chk("single_r", out_r, -5);
        chk("single_i", out_i, 7);
        chk("single_perr", protocol_err, 0);

        // reset mid-frame, with a beat presented during reset
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        beat(2, 9, 9, 1, 0);
        beat(2, 9, 9, 0, 0);
        reset = 1'b1;
        in_ch = 1; in_r = 50; in_i = 50; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        chk("rst2_valid", out_valid, 0);
        chk("rst2_r", out_r, 0);
        chk("rst2_perr", protocol_err, 0);
        chk("rst2_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("rst2_dropped_beat", out_valid, 0);
        push(2, 4, 4, 0);
        beat(2, 1, 1, 1, 0);
        chk("rst2_perr_first", protocol_err, 0);
        beat(2, 1, 1, 0, 0);
        beat(2, 1, 1, 0, 0);
        beat(2, 1, 1, 0, 1);
        chk("rst2_frame_r", out_r, 4);
        chk("rst2_frame_ovf", out_overflow, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty_end", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
